// File: rtl/hood_pkg.sv
// Shared types and constants for the range-hood mode sequencer.
// The optional once-per-power-on hurricane limit is HOOD_LEVEL3_ONCE_EN (see hood_mode_ctrl).
package hood_pkg;

    typedef enum logic [2:0] {
        M_OFF,
        M_STANDBY,
        M_MENU,
        M_EXTRACT,
        M_HURRICANE,
        M_CLEAN,
        M_SET_CLK,
        M_SET_REM
    } mode_e;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_EXTRACT = 2'b01;
    localparam logic [1:0] ST_CLEAN   = 2'b11;

    localparam logic [1:0] SAT_RUN    = 2'b00;
    localparam logic [1:0] SAT_CLOCK  = 2'b01;
    localparam logic [1:0] SAT_REMIND = 2'b10;

    localparam int DEF_TICKS_PER_SEC    = 100;
    localparam int DEF_LONG_PRESS_TICKS = 300;
    localparam int DEF_HURRICANE_SECS   = 60;
    localparam int DEF_CLEAN_SECS       = 180;

    function automatic logic [1:0] state_code(input mode_e m);
        case (m)
            M_EXTRACT, M_HURRICANE: return ST_EXTRACT;
            M_CLEAN:                return ST_CLEAN;
            default:                return ST_IDLE;
        endcase
    endfunction

    function automatic logic [1:0] sat_code(input mode_e m);
        case (m)
            M_SET_CLK: return SAT_CLOCK;
            M_SET_REM: return SAT_REMIND;
            default:   return SAT_RUN;
        endcase
    endfunction

endpackage

// File: rtl/hood_countdown.sv
// Tick prescaler plus seconds down-counter for the timed hood modes.
// expire pulses combinationally on the tick that takes the count from 1 to 0.
module hood_countdown
    import hood_pkg::*;
#(
    parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    input  logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             expire
);

    localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    logic [PRE_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wrap;

    assign wrap   = tick && (presc_q == PRE_W'(TICKS_PER_SEC - 1));
    assign expire = wrap && (count_q == CNT_W'(1));
    assign count  = count_q;

    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        if (load) begin
            presc_d = '0;
            count_d = value;
        end else if (wrap) begin
            presc_d = '0;
            if (count_q != '0) begin
                count_d = count_q - CNT_W'(1);
            end
        end else if (tick) begin
            presc_d = presc_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            count_q <= '0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/hood_mode_ctrl.sv
// Range-hood mode sequencer: panel buttons to power/state/set-mode/fan/countdown outputs.
// Define HOOD_LEVEL3_ONCE_EN to allow hurricane mode only once per power-on.
module hood_mode_ctrl
    import hood_pkg::*;
#(
    parameter int TICKS_PER_SEC    = DEF_TICKS_PER_SEC,
    parameter int LONG_PRESS_TICKS = DEF_LONG_PRESS_TICKS,
    parameter int HURRICANE_SECS   = DEF_HURRICANE_SECS,
    parameter int CLEAN_SECS       = DEF_CLEAN_SECS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_100hz,
    input  logic       btn_power,
    input  logic       btn_menu,
    input  logic       btn_set,
    input  logic       btn_clean,
    input  logic       btn_level1,
    input  logic       btn_level2,
    input  logic       btn_level3,
    output logic       power_on,
    output logic [1:0] state,
    output logic [1:0] set_all_times,
    output logic [1:0] fan_level,
    output logic [7:0] countdown
);

    localparam int HOLD_W = $clog2(LONG_PRESS_TICKS + 1);

    mode_e             mode_q, mode_d;
    logic [6:0]        btn_now, btn_prev_q, btn_prev_d, btn_rise;
    logic              rise_pwr, rise_menu, rise_set, rise_clean;
    logic              rise_l1, rise_l2, rise_l3;
    logic [1:0]        fan_q, fan_d;
    logic              power_on_q, power_on_d;
    logic [1:0]        st_code_q, st_code_d;
    logic [1:0]        sat_q, sat_d;
    logic              armed_q, armed_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              force_off;
    logic              l3_ok;
    logic              cd_load, cd_expire;
    logic [7:0]        cd_value, cd_count;

    assign btn_now    = {btn_power, btn_menu, btn_set, btn_clean, btn_level1, btn_level2, btn_level3};
    assign btn_prev_d = btn_now;
    assign btn_rise   = btn_now & ~btn_prev_q;
    assign {rise_pwr, rise_menu, rise_set, rise_clean, rise_l1, rise_l2, rise_l3} = btn_rise;

    // The long-press only arms once the button has been seen released, so the
    // press that powered the hood up cannot immediately power it back down.
    assign force_off = (mode_q != M_OFF) && armed_q && btn_power && tick_100hz
                       && (hold_q == HOLD_W'(LONG_PRESS_TICKS - 1));

    always_comb begin
        armed_d = (mode_q != M_OFF) && !force_off && (armed_q || !btn_power);
        hold_d  = hold_q;
        if ((mode_q == M_OFF) || !armed_q || !btn_power || force_off) begin
            hold_d = '0;
        end else if (tick_100hz) begin
            hold_d = hold_q + HOLD_W'(1);
        end
    end

`ifdef HOOD_LEVEL3_ONCE_EN
    logic l3_used_q, l3_used_d;

    assign l3_ok = !l3_used_q;

    always_comb begin
        l3_used_d = l3_used_q;
        if (force_off) begin
            l3_used_d = 1'b0;
        end else if ((mode_d == M_HURRICANE) && (mode_q != M_HURRICANE)) begin
            l3_used_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l3_used_q <= 1'b0;
        end else begin
            l3_used_q <= l3_used_d;
        end
    end
`else
    assign l3_ok = 1'b1;
`endif

    always_comb begin
        mode_d = mode_q;
        fan_d  = fan_q;
        case (mode_q)
            M_OFF: begin
                if (rise_pwr) mode_d = M_STANDBY;
            end
            M_STANDBY: begin
                if (rise_menu)     mode_d = M_MENU;
                else if (rise_set) mode_d = M_SET_CLK;
            end
            M_MENU: begin
                if (rise_menu) begin
                    mode_d = M_STANDBY;
                end else if (rise_l3) begin
                    if (l3_ok) mode_d = M_HURRICANE;
                end else if (rise_l2) begin
                    mode_d = M_EXTRACT;
                    fan_d  = 2'd2;
                end else if (rise_l1) begin
                    mode_d = M_EXTRACT;
                    fan_d  = 2'd1;
                end else if (rise_clean) begin
                    mode_d = M_CLEAN;
                end
            end
            M_EXTRACT: begin
                if (rise_menu)    mode_d = M_STANDBY;
                else if (rise_l2) fan_d  = 2'd2;
                else if (rise_l1) fan_d  = 2'd1;
            end
            M_HURRICANE: begin
                if (cd_expire) begin
                    mode_d = M_EXTRACT;
                    fan_d  = 2'd2;
                end
            end
            M_CLEAN: begin
                if (cd_expire) mode_d = M_STANDBY;
            end
            M_SET_CLK: begin
                if (rise_set)       mode_d = M_SET_REM;
                else if (rise_menu) mode_d = M_STANDBY;
            end
            M_SET_REM: begin
                if (rise_set || rise_menu) mode_d = M_STANDBY;
            end
            default: mode_d = M_OFF;
        endcase

        if (force_off) mode_d = M_OFF;

        if (mode_d == M_HURRICANE)     fan_d = 2'd3;
        else if (mode_d != M_EXTRACT)  fan_d = 2'd0;

        power_on_d = (mode_d != M_OFF);
        st_code_d  = state_code(mode_d);
        sat_d      = sat_code(mode_d);
    end

    // Outside the timed modes the counter is held loaded with zero, so countdown
    // reads 0 there and restarts cleanly on each entry.
    always_comb begin
        cd_value = 8'd0;
        if (mode_d == M_HURRICANE)  cd_value = 8'(HURRICANE_SECS);
        else if (mode_d == M_CLEAN) cd_value = 8'(CLEAN_SECS);
        cd_load = ((mode_d != M_HURRICANE) && (mode_d != M_CLEAN)) || (mode_d != mode_q);
    end

    hood_countdown #(
        .TICKS_PER_SEC(TICKS_PER_SEC),
        .CNT_W        (8)
    ) u_countdown (
        .clk   (clk),
        .reset (reset),
        .load  (cd_load),
        .value (cd_value),
        .tick  (tick_100hz),
        .count (cd_count),
        .expire(cd_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q     <= M_OFF;
            btn_prev_q <= '0;
            fan_q      <= 2'd0;
            power_on_q <= 1'b0;
            st_code_q  <= ST_IDLE;
            sat_q      <= SAT_RUN;
            armed_q    <= 1'b0;
            hold_q     <= '0;
        end else begin
            mode_q     <= mode_d;
            btn_prev_q <= btn_prev_d;
            fan_q      <= fan_d;
            power_on_q <= power_on_d;
            st_code_q  <= st_code_d;
            sat_q      <= sat_d;
            armed_q    <= armed_d;
            hold_q     <= hold_d;
        end
    end

    assign power_on      = power_on_q;
    assign state         = st_code_q;
    assign set_all_times = sat_q;
    assign fan_level     = fan_q;
    assign countdown     = cd_count;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// Self-checking bench for hood_mode_ctrl: vector table, directed timed sequences,
// and randomized buttons/ticks against a tick-counting reference model.
module tb_hood_mode_ctrl;

    localparam int TPS   = 100;
    localparam int LONGP = 300;
    localparam int HSECS = 60;
    localparam int CSECS = 180;
`ifdef HOOD_LEVEL3_ONCE_EN
    localparam bit L3_LIMIT = 1'b1;
`else
    localparam bit L3_LIMIT = 1'b0;
`endif

    localparam int S_OFF = 0, S_STBY = 1, S_MENU = 2, S_EXT = 3;
    localparam int S_HUR = 4, S_CLN = 5, S_SETC = 6, S_SETR = 7;

    localparam logic [7:0] P = 8'h80, M = 8'h40, S = 8'h20, C = 8'h10;
    localparam logic [7:0] L1 = 8'h08, L2 = 8'h04, L3 = 8'h02, Z = 8'h00;

    logic       clk = 1'b0;
    logic       reset, tick;
    logic       bp, bm, bs, bc, b1, b2, b3;
    logic       power_on;
    logic [1:0] state, set_all_times, fan_level;
    logic [7:0] countdown;
    logic [14:0] dut_out;

    always #5 clk = ~clk;

    hood_mode_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .tick_100hz   (tick),
        .btn_power    (bp),
        .btn_menu     (bm),
        .btn_set      (bs),
        .btn_clean    (bc),
        .btn_level1   (b1),
        .btn_level2   (b2),
        .btn_level3   (b3),
        .power_on     (power_on),
        .state        (state),
        .set_all_times(set_all_times),
        .fan_level    (fan_level),
        .countdown    (countdown)
    );

    assign dut_out = {power_on, state, set_all_times, fan_level, countdown};

    int nvec = 0;
    int nfail = 0;

    // Reference model: mode, selected extract level, ticks spent in the timed mode.
    int       m_mode, m_level, m_elapsed, m_hold;
    bit       m_armed, m_l3used;
    bit [6:0] m_prev;

    function automatic logic [14:0] pack_out(input logic pon, input logic [1:0] st,
                                             input logic [1:0] sat, input logic [1:0] fan,
                                             input logic [7:0] cd);
        return {pon, st, sat, fan, cd};
    endfunction

    function automatic logic [14:0] model_out();
        logic [1:0] st, sat, fan;
        logic [7:0] cd;
        st  = (m_mode == S_EXT || m_mode == S_HUR) ? 2'b01 : (m_mode == S_CLN) ? 2'b11 : 2'b00;
        sat = (m_mode == S_SETC) ? 2'b01 : (m_mode == S_SETR) ? 2'b10 : 2'b00;
        fan = (m_mode == S_EXT) ? 2'(m_level) : (m_mode == S_HUR) ? 2'd3 : 2'd0;
        cd  = (m_mode == S_HUR) ? 8'(HSECS - m_elapsed / TPS) :
              (m_mode == S_CLN) ? 8'(CSECS - m_elapsed / TPS) : 8'd0;
        return pack_out(m_mode != S_OFF, st, sat, fan, cd);
    endfunction

    task automatic model_reset();
        m_mode = S_OFF; m_level = 0; m_elapsed = 0; m_hold = 0;
        m_armed = 0; m_l3used = 0; m_prev = '0;
    endtask

    task automatic model_clock();
        bit [6:0] now, rise;
        bit       lp, n_armed;
        int       nm, nl, n_hold;
        now  = {bp, bm, bs, bc, b1, b2, b3};
        rise = now & ~m_prev;
        lp   = (m_mode != S_OFF) && m_armed && bp && tick && (m_hold + 1 == LONGP);
        n_armed = (m_mode != S_OFF) && !lp && (m_armed || !bp);
        n_hold  = ((m_mode != S_OFF) && m_armed && bp && !lp) ? m_hold + int'(tick) : 0;
        nm = m_mode;
        nl = m_level;
        case (m_mode)
            S_OFF:  if (rise[6]) nm = S_STBY;
            S_STBY: if (rise[5]) nm = S_MENU; else if (rise[4]) nm = S_SETC;
            S_MENU: begin
                if (rise[5]) nm = S_STBY;
                else if (rise[0]) begin
                    if (!L3_LIMIT || !m_l3used) nm = S_HUR;
                end
                else if (rise[1]) begin nm = S_EXT; nl = 2; end
                else if (rise[2]) begin nm = S_EXT; nl = 1; end
                else if (rise[3]) nm = S_CLN;
            end
            S_EXT: if (rise[5]) nm = S_STBY; else if (rise[1]) nl = 2; else if (rise[2]) nl = 1;
            S_HUR: if (tick && (m_elapsed + 1 == HSECS * TPS)) begin nm = S_EXT; nl = 2; end
            S_CLN: if (tick && (m_elapsed + 1 == CSECS * TPS)) nm = S_STBY;
            S_SETC: if (rise[4]) nm = S_SETR; else if (rise[5]) nm = S_STBY;
            S_SETR: if (rise[4] || rise[5]) nm = S_STBY;
            default: nm = S_OFF;
        endcase
        if (lp) nm = S_OFF;
        if ((nm == S_HUR || nm == S_CLN) && nm == m_mode) m_elapsed += int'(tick);
        else m_elapsed = 0;
        if (lp) m_l3used = 0;
        else if (nm == S_HUR && m_mode != S_HUR) m_l3used = 1;
        m_mode  = nm;
        m_level = nl;
        m_armed = n_armed;
        m_hold  = n_hold;
        m_prev  = now;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        chk("model", {17'd0, dut_out}, {17'd0, model_out()});
    endtask

    task automatic set_in(input logic [7:0] v);
        {bp, bm, bs, bc, b1, b2, b3, tick} = v;
    endtask

    task automatic pulse(input logic [7:0] v);
        set_in(v);
        step();
        set_in({bp, 7'd0} & 8'h80);
        step();
    endtask

    task automatic run_ticks(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [14:0] exp);
        chk(name, {17'd0, dut_out}, {17'd0, exp});
    endtask

    typedef struct {
        logic [7:0]  in;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] o_off, o_stb, o_cln1, o_hur60;
        logic [6:0]  rb;
        o_off   = pack_out(0, 2'b00, 2'b00, 2'd0, 8'd0);
        o_stb   = pack_out(1, 2'b00, 2'b00, 2'd0, 8'd0);
        o_cln1  = pack_out(1, 2'b11, 2'b00, 2'd0, 8'd1);
        o_hur60 = pack_out(1, 2'b01, 2'b00, 2'd3, 8'd60);

        tbl.push_back('{Z,       o_off});
        tbl.push_back('{M,       o_off});
        tbl.push_back('{Z,       o_off});
        tbl.push_back('{P,       o_stb});
        tbl.push_back('{Z,       o_stb});
        tbl.push_back('{L1,      o_stb});
        tbl.push_back('{Z,       o_stb});
        tbl.push_back('{M,       o_stb});
        tbl.push_back('{Z,       o_stb});
        tbl.push_back('{L1,      pack_out(1, 2'b01, 2'b00, 2'd1, 8'd0)});
        tbl.push_back('{Z,       pack_out(1, 2'b01, 2'b00, 2'd1, 8'd0)});
        tbl.push_back('{L2,      pack_out(1, 2'b01, 2'b00, 2'd2, 8'd0)});
        tbl.push_back('{Z,       pack_out(1, 2'b01, 2'b00, 2'd2, 8'd0)});
        tbl.push_back('{L1,      pack_out(1, 2'b01, 2'b00, 2'd1, 8'd0)});
        tbl.push_back('{Z,       pack_out(1, 2'b01, 2'b00, 2'd1, 8'd0)});
        tbl.push_back('{L3,      pack_out(1, 2'b01, 2'b00, 2'd1, 8'd0)});
        tbl.push_back('{Z,       pack_out(1, 2'b01, 2'b00, 2'd1, 8'd0)});
        tbl.push_back('{L1 | L2, pack_out(1, 2'b01, 2'b00, 2'd2, 8'd0)});
        tbl.push_back('{Z,       pack_out(1, 2'b01, 2'b00, 2'd2, 8'd0)});
        tbl.push_back('{M,       o_stb});
        tbl.push_back('{Z,       o_stb});
        tbl.push_back('{S,       pack_out(1, 2'b00, 2'b01, 2'd0, 8'd0)});
        tbl.push_back('{Z,       pack_out(1, 2'b00, 2'b01, 2'd0, 8'd0)});
        tbl.push_back('{S,       pack_out(1, 2'b00, 2'b10, 2'd0, 8'd0)});
        tbl.push_back('{Z,       pack_out(1, 2'b00, 2'b10, 2'd0, 8'd0)});
        tbl.push_back('{M,       o_stb});
        tbl.push_back('{Z,       o_stb});
        tbl.push_back('{M,       o_stb});
        tbl.push_back('{Z,       o_stb});
        tbl.push_back('{L1 | L2, pack_out(1, 2'b01, 2'b00, 2'd2, 8'd0)});
        tbl.push_back('{Z,       pack_out(1, 2'b01, 2'b00, 2'd2, 8'd0)});
        tbl.push_back('{M,       o_stb});
        tbl.push_back('{Z,       o_stb});
        tbl.push_back('{S,       pack_out(1, 2'b00, 2'b01, 2'd0, 8'd0)});
        tbl.push_back('{Z,       pack_out(1, 2'b00, 2'b01, 2'd0, 8'd0)});
        tbl.push_back('{M,       o_stb});
        tbl.push_back('{Z,       o_stb});
        tbl.push_back('{P,       o_stb});
        tbl.push_back('{Z,       o_stb});

        set_in(Z);
        reset = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        expect_out("reset", o_off);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            set_in(tbl[i].in);
            step();
            chk($sformatf("vec%0d", i), {17'd0, dut_out}, {17'd0, tbl[i].exp});
        end

        // Long press: 299 ticks is not enough, 300 forces OFF.
        bp = 1'b1;
        run_ticks(LONGP - 1);
        expect_out("hold299", o_stb);
        bp = 1'b0;
        step();
        expect_out("release299", o_stb);
        bp = 1'b1;
        run_ticks(LONGP - 1);
        expect_out("hold299b", o_stb);
        run_ticks(1);
        expect_out("long300", o_off);
        step();
        expect_out("held_in_off", o_off);
        bp = 1'b0;
        step();
        pulse(P);
        expect_out("repower", o_stb);

        // Hurricane runs 6000 ticks then drops to extract level 2.
        pulse(M);
        pulse(L3);
        expect_out("hur_entry", o_hur60);
        run_ticks(TPS);
        expect_out("hur_59", pack_out(1, 2'b01, 2'b00, 2'd3, 8'd59));
        run_ticks(HSECS * TPS - TPS - 1);
        expect_out("hur_1", pack_out(1, 2'b01, 2'b00, 2'd3, 8'd1));
        run_ticks(1);
        expect_out("hur_expire", pack_out(1, 2'b01, 2'b00, 2'd2, 8'd0));
        pulse(M);
        expect_out("ext_to_stby", o_stb);
`ifdef HOOD_LEVEL3_ONCE_EN
        pulse(M);
        pulse(L3);
        expect_out("l3_once_held", o_stb);
        pulse(M);
`endif

        // Self-clean runs 18000 ticks then returns to standby.
        pulse(M);
        pulse(C);
        expect_out("cln_entry", pack_out(1, 2'b11, 2'b00, 2'd0, 8'd180));
        pulse(M);
        expect_out("cln_ignores_menu", pack_out(1, 2'b11, 2'b00, 2'd0, 8'd180));
        run_ticks(TPS);
        expect_out("cln_179", pack_out(1, 2'b11, 2'b00, 2'd0, 8'd179));
        run_ticks(CSECS * TPS - TPS - 1);
        expect_out("cln_1", o_cln1);
        run_ticks(1);
        expect_out("cln_expire", o_stb);

        // Long press completing on the very tick the clean countdown expires.
        pulse(M);
        pulse(C);
        run_ticks(CSECS * TPS - LONGP);
        bp = 1'b1;
        run_ticks(LONGP - 1);
        expect_out("lp_pre", o_cln1);
        run_ticks(1);
        expect_out("lp_vs_expire", o_off);
        bp = 1'b0;
        step();
        pulse(P);

        // After a power cycle, level 3 is accepted; reset aborts it mid-countdown.
        pulse(M);
        pulse(L3);
        expect_out("l3_after_cycle", o_hur60);
        run_ticks(250);
        expect_out("hur_58", pack_out(1, 2'b01, 2'b00, 2'd3, 8'd58));
        #2;
        reset = 1'b1;
        #1;
        expect_out("async_reset", o_off);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // Randomized buttons and ticks against the model.
        pulse(P);
        for (int n = 0; n < 6000; n++) begin
            rb = {bp, bm, bs, bc, b1, b2, b3};
            if ($urandom_range(0, 39) == 0) rb[6] = ~rb[6];
            for (int k = 0; k < 6; k++) begin
                if ($urandom_range(0, 5) == 0) rb[k] = ~rb[k];
            end
            {bp, bm, bs, bc, b1, b2, b3} = rb;
            tick = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
